// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N:1 streaming multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/stream_mux_n_1_if.sv
// Handshake and data bundle between the input producers, the mux and its consumer.
interface stream_mux_n_1_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

  logic                         Enable_In;
  logic                         Mode_In;
  logic [SEL_WIDTH-1:0]         Select_In;
  logic [NUM_CH*DATA_WIDTH-1:0] Data_In;
  logic [NUM_CH-1:0]            Valid_In;
  logic [NUM_CH-1:0]            Last_In;
  logic [NUM_CH-1:0]            Ready_Out;
  logic [DATA_WIDTH-1:0]        MUX_Data_Out;
  logic                         MUX_Last_Out;
  logic [SEL_WIDTH-1:0]         MUX_Channel_Out;
  logic                         MUX_Valid_Out;
  logic                         MUX_Ready_In;

  modport master (
    output Enable_In, Mode_In, Select_In, Data_In, Valid_In, Last_In, MUX_Ready_In,
    input  Ready_Out, MUX_Data_Out, MUX_Last_Out, MUX_Channel_Out, MUX_Valid_Out
  );

  modport slave (
    input  Enable_In, Mode_In, Select_In, Data_In, Valid_In, Last_In, MUX_Ready_In,
    output Ready_Out, MUX_Data_Out, MUX_Last_Out, MUX_Channel_Out, MUX_Valid_Out
  );

endinterface

// File: rtl/stream_mux_n_1_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or above Pointer_In, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         Request_In,
  input  logic [$clog2(NUM_CH)-1:0] Pointer_In,
  output logic [NUM_CH-1:0]         Grant_Out
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

  logic                 found_c;
  logic [SEL_WIDTH-1:0] idx_c;
  int unsigned          pos_c;

  always_comb begin
    Grant_Out = '0;
    found_c   = 1'b0;
    idx_c     = '0;
    pos_c     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos_c = 32'(Pointer_In) + i;
      if (pos_c >= NUM_CH) pos_c = pos_c - NUM_CH;
      idx_c = SEL_WIDTH'(pos_c);
      if (!found_c && Request_In[idx_c]) begin
        Grant_Out[idx_c] = 1'b1;
        found_c          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream mux with fixed or round-robin selection, packet lock and a
// one-deep registered output stage that runs at full rate.
module stream_mux_n_1
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           Clk_In,
  input logic           Reset_N_In,
  stream_mux_n_1_if.slave bus
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

  arb_state_t            arb_q, arb_d;
  out_state_t            out_q, out_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]  chan_q, chan_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  logic                  load_ok_c;
  logic [NUM_CH-1:0]     rr_grant_c;
  logic [NUM_CH-1:0]     grant_c;
  logic [NUM_CH-1:0]     ready_c;
  logic                  xfer_c;
  logic [SEL_WIDTH-1:0]  xfer_ch_c;
  logic                  xfer_last_c;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .Request_In (bus.Valid_In),
    .Pointer_In (ptr_q),
    .Grant_Out  (rr_grant_c)
  );

  // While locked, chan_q still names the channel that opened the packet.
  always_comb begin
    grant_c = '0;
    if (arb_q == ARB_LOCKED) begin
      grant_c[chan_q] = 1'b1;
    end else if (bus.Mode_In == MODE_RR) begin
      grant_c = rr_grant_c;
    end else if (32'(bus.Select_In) < NUM_CH) begin
      grant_c[bus.Select_In] = 1'b1;
    end
  end

  // Output slot is free when empty or being drained this cycle.
  assign load_ok_c = bus.Enable_In & ((out_q == OUT_EMPTY) | bus.MUX_Ready_In);
  assign ready_c   = grant_c & {NUM_CH{load_ok_c & Reset_N_In}};
  assign xfer_c    = |(bus.Valid_In & ready_c);

  always_comb begin
    xfer_ch_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_c[c]) xfer_ch_c = SEL_WIDTH'(c);
    end
  end

  assign xfer_last_c = bus.Last_In[xfer_ch_c];

  always_comb begin
    arb_d  = arb_q;
    out_d  = out_q;
    ptr_d  = ptr_q;
    chan_d = chan_q;
    data_d = data_q;
    last_d = last_q;
    if (xfer_c) begin
      out_d  = OUT_FULL;
      chan_d = xfer_ch_c;
      data_d = bus.Data_In[xfer_ch_c*DATA_WIDTH +: DATA_WIDTH];
      last_d = xfer_last_c;
      if (xfer_last_c) begin
        arb_d = ARB_OPEN;
        ptr_d = (32'(xfer_ch_c) == NUM_CH - 1) ? '0 : xfer_ch_c + SEL_WIDTH'(1);
      end else begin
        arb_d = ARB_LOCKED;
      end
    end else if ((out_q == OUT_FULL) && bus.MUX_Ready_In) begin
      out_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      arb_q  <= ARB_OPEN;
      out_q  <= OUT_EMPTY;
      ptr_q  <= '0;
      chan_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      arb_q  <= arb_d;
      out_q  <= out_d;
      ptr_q  <= ptr_d;
      chan_q <= chan_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign bus.Ready_Out       = ready_c;
  assign bus.MUX_Valid_Out   = (out_q == OUT_FULL);
  assign bus.MUX_Data_Out    = data_q;
  assign bus.MUX_Last_Out    = last_q;
  assign bus.MUX_Channel_Out = chan_q;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Directed bench for stream_mux_n_1 (NUM_CH=4, DATA_WIDTH=8) with hand-computed expectations.
module tb_stream_mux_n_1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  stream_mux_n_1_if #(.NUM_CH(4), .DATA_WIDTH(8)) bus ();

  stream_mux_n_1 #(.NUM_CH(4), .DATA_WIDTH(8)) dut (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [7:0] v);
    bus.Data_In[c*8 +: 8] = v;
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic [7:0] d,
                           input logic last);
    check_eq({tag, "_valid"}, 32'(bus.MUX_Valid_Out), 32'd1);
    check_eq({tag, "_chan"},  32'(bus.MUX_Channel_Out), 32'(ch));
    check_eq({tag, "_data"},  32'(bus.MUX_Data_Out), 32'(d));
    check_eq({tag, "_last"},  32'(bus.MUX_Last_Out), 32'(last));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n            = 1'b0;
    bus.Enable_In    = 1'b1;
    bus.Mode_In      = 1'b0;
    bus.Select_In    = 2'd0;
    bus.Data_In      = '0;
    bus.Valid_In     = '0;
    bus.Last_In      = '0;
    bus.MUX_Ready_In = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: outputs cleared, no ready even with valid inputs.
    bus.Valid_In = 4'hF;
    #1;
    check_eq("rst_ready", 32'(bus.Ready_Out), 32'h0);
    check_eq("rst_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    check_eq("rst_data",  32'(bus.MUX_Data_Out), 32'h0);
    check_eq("rst_chan",  32'(bus.MUX_Channel_Out), 32'h0);
    check_eq("rst_last",  32'(bus.MUX_Last_Out), 32'h0);
    bus.Valid_In = '0;
    rst_n = 1'b1;
    step();

    // Fixed select on channel 2.
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'hA5); set_data(3, 8'h44);
    bus.Valid_In = 4'hF;
    bus.Last_In  = 4'b0100;
    bus.Select_In = 2'd2;
    #1;
    check_eq("fix_ready", 32'(bus.Ready_Out), 32'h4);
    step();
    check_out("fix", 2'd2, 8'hA5, 1'b1);
    bus.Valid_In = '0;
    step();
    check_eq("fix_drain_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    check_eq("fix_hold_data", 32'(bus.MUX_Data_Out), 32'hA5);

    // Round-robin from a fresh reset: 0,1,2,3,0 back to back.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    bus.Mode_In = 1'b1;
    bus.Valid_In = 4'hF;
    bus.Last_In  = 4'hF;
    for (int c = 0; c < 4; c++) set_data(c, 8'(8'h10 + c));
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_ready", 32'(bus.Ready_Out), 32'(1 << (k % 4)));
      step();
      check_out("rr", 2'(k % 4), 8'(8'h10 + (k % 4)), 1'b1);
    end
    bus.Valid_In = '0;
    step();
    check_eq("rr_drain_valid", 32'(bus.MUX_Valid_Out), 32'h0);

    // Packet lock on ch1 while Mode/Select toggle; pointer then moves to ch2.
    bus.Valid_In = 4'b0111;
    bus.Last_In  = 4'b0101;
    set_data(0, 8'h30); set_data(1, 8'h21); set_data(2, 8'h32);
    #1;
    check_eq("lock_ready1", 32'(bus.Ready_Out), 32'h2);
    step();
    check_out("lock_b1", 2'd1, 8'h21, 1'b0);
    bus.Mode_In = 1'b0;
    bus.Select_In = 2'd0;
    set_data(1, 8'h22);
    #1;
    check_eq("lock_ready2", 32'(bus.Ready_Out), 32'h2);
    step();
    check_out("lock_b2", 2'd1, 8'h22, 1'b0);
    bus.Mode_In = 1'b1;
    bus.Select_In = 2'd2;
    bus.Last_In = 4'b0111;
    set_data(1, 8'h23);
    #1;
    check_eq("lock_ready3", 32'(bus.Ready_Out), 32'h2);
    step();
    check_out("lock_b3", 2'd1, 8'h23, 1'b1);
    bus.Valid_In = 4'b0101;
    #1;
    check_eq("unlock_ready", 32'(bus.Ready_Out), 32'h4);
    step();
    check_out("unlock", 2'd2, 8'h32, 1'b1);
    bus.Valid_In = '0;
    step();

    // Backpressure: 3C held for 5 clocks, then 4D loaded on the draining cycle.
    bus.Mode_In = 1'b0;
    bus.Select_In = 2'd3;
    bus.Valid_In = 4'b1000;
    bus.Last_In  = 4'b1000;
    set_data(3, 8'h3C);
    step();
    check_out("bp_load", 2'd3, 8'h3C, 1'b1);
    bus.MUX_Ready_In = 1'b0;
    set_data(3, 8'h4D);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_ready", 32'(bus.Ready_Out), 32'h0);
      step();
      check_out("bp_hold", 2'd3, 8'h3C, 1'b1);
    end
    bus.MUX_Ready_In = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.Ready_Out), 32'h8);
    step();
    check_out("bp_next", 2'd3, 8'h4D, 1'b1);
    bus.Valid_In = '0;
    step();
    check_eq("bp_drain_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    check_eq("bp_hold_data", 32'(bus.MUX_Data_Out), 32'h4D);

    // Enable low: nothing accepted, held beat still drains.
    bus.Valid_In = 4'b1000;
    set_data(3, 8'h55);
    step();
    check_out("en_load", 2'd3, 8'h55, 1'b1);
    bus.Enable_In = 1'b0;
    #1;
    check_eq("en_ready", 32'(bus.Ready_Out), 32'h0);
    step();
    check_eq("en_drain_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    check_eq("en_hold_data", 32'(bus.MUX_Data_Out), 32'h55);
    step();
    check_eq("en_idle_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    // Fixed select on an idle channel: ch3 valid is not taken.
    bus.Enable_In = 1'b1;
    bus.Select_In = 2'd1;
    #1;
    check_eq("sel_idle_ready", 32'(bus.Ready_Out), 32'h2);
    step();
    check_eq("sel_idle_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    bus.Valid_In = '0;

    // Reset mid-packet: clears output, lock and pointer immediately.
    bus.Mode_In = 1'b1;
    bus.Valid_In = 4'b0010;
    bus.Last_In  = 4'b0010;
    set_data(1, 8'h71);
    step();
    check_out("mid_pre", 2'd1, 8'h71, 1'b1);
    bus.Valid_In = 4'b1000;
    bus.Last_In  = 4'b0000;
    set_data(3, 8'h61);
    #1;
    check_eq("mid_ready", 32'(bus.Ready_Out), 32'h8);
    step();
    check_out("mid_b1", 2'd3, 8'h61, 1'b0);
    bus.Valid_In = 4'hF;
    bus.Last_In  = 4'hF;
    set_data(0, 8'h60);
    #1;
    check_eq("mid_lock_ready", 32'(bus.Ready_Out), 32'h8);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.MUX_Valid_Out), 32'h0);
    check_eq("mid_rst_data",  32'(bus.MUX_Data_Out), 32'h0);
    check_eq("mid_rst_chan",  32'(bus.MUX_Channel_Out), 32'h0);
    check_eq("mid_rst_ready", 32'(bus.Ready_Out), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(bus.Ready_Out), 32'h1);
    step();
    check_out("post_rst", 2'd0, 8'h60, 1'b1);
    bus.Valid_In = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
